// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall, execute-stage redirects and a
// circular return-address stack (RAS) for call/return prediction.
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous, active-high reset
//   stall            hold the current fetch address
//   jump             redirect to jump_location
//   jump_location    jump target
//   call             with jump: push the return address (pc + STEP) onto the RAS
//   ret              redirect to the RAS top and pop (ignored when the RAS is empty)
//   next_instruction current fetch address (registered)
//   ras_empty        RAS holds no entries (decoded from the registered count)
//   ras_full         RAS holds RAS_DEPTH entries (decoded from the registered count)
//   ras_underflow    one-cycle pulse: ret issued while the RAS was empty
//   misaligned       (PC_ALIGN_CHECK_EN only) one-cycle pulse: taken jump with
//                    jump_location[1:0] != 0; the target is loaded word-aligned
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//
// Priority on each rising edge: ret (RAS non-empty) > jump > stall > increment.

module pc_unit #(
    parameter int unsigned                ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]      RESET_VECTOR = '0,
    parameter int unsigned                STEP         = 4,
    parameter int unsigned                RAS_DEPTH    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_location,
    input  logic                  call,
    input  logic                  ret,
    output logic [ADDR_WIDTH-1:0] next_instruction,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_underflow
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                  misaligned
`endif
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]      r_top;       // next slot to write; top entry sits at r_top-1
    logic [CNT_W-1:0]      r_count;
    logic                  r_underflow;
`ifdef PC_ALIGN_CHECK_EN
    logic                  r_misaligned;
`endif

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_ret_empty;
    logic                  w_jump_taken;
    logic                  w_push;
    logic [PTR_W-1:0]      w_top_idx;
    logic [ADDR_WIDTH-1:0] w_pc_seq;
    logic [ADDR_WIDTH-1:0] w_jump_target;
    logic [ADDR_WIDTH-1:0] w_pc_next;

    // RAS status decoded from the registered occupancy count
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_COUNT);
    assign ras_empty = w_empty;
    assign ras_full  = w_full;

    // A ret against an empty stack falls through to jump/stall/increment
    assign w_pop        = ret && !w_empty;
    assign w_ret_empty  = ret && w_empty;
    assign w_jump_taken = jump && !w_pop;
    assign w_push       = w_jump_taken && call;

    assign w_top_idx = r_top - PTR_W'(1);
    assign w_pc_seq  = r_pc + ADDR_WIDTH'(STEP);

`ifdef PC_ALIGN_CHECK_EN
    assign w_jump_target = {jump_location[ADDR_WIDTH-1:2], 2'b00};
`else
    assign w_jump_target = jump_location;
`endif

    // Next fetch address selection
    always_comb begin
        w_pc_next = w_pc_seq;
        if (w_pop) begin
            w_pc_next = r_ras[w_top_idx];
        end else if (w_jump_taken) begin
            w_pc_next = w_jump_target;
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    // Program counter and status pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_underflow <= w_ret_empty;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Flags a taken jump whose target is not word-aligned
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_jump_taken && (jump_location[1:0] != 2'b00);
        end
    end

    assign misaligned = r_misaligned;
`endif

    // Circular return-address stack; a push when full overwrites the oldest entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_push) begin
            r_ras[r_top] <= w_pc_seq;
            r_top        <= r_top + PTR_W'(1);
            if (!w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_pop) begin
            r_top   <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign next_instruction = r_pc;
    assign ras_underflow    = r_underflow;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit with default parameters
// (ADDR_WIDTH=32, RESET_VECTOR=0, STEP=4, RAS_DEPTH=4).

module tb_pc_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [31:0] jump_location;
    logic        call;
    logic        ret;
    logic [31:0] next_instruction;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pc_unit #(
        .ADDR_WIDTH   (32),
        .RESET_VECTOR (32'h0),
        .STEP         (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .jump             (jump),
        .jump_location    (jump_location),
        .call             (call),
        .ret              (ret),
        .next_instruction (next_instruction),
        .ras_empty        (ras_empty),
        .ras_full         (ras_full),
        .ras_underflow    (ras_underflow)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned       (misaligned)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0;
        jump = 1'b0;
        call = 1'b0;
        ret = 1'b0;
        jump_location = 32'h0;
    endtask

    task automatic do_jump(input logic [31:0] loc, input logic with_call);
        jump = 1'b1;
        call = with_call;
        jump_location = loc;
        step();
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clock);
        #1;
        check("reset_pc", next_instruction, 32'h0);
        check("reset_empty", 32'(ras_empty), 32'd1);
        check("reset_full", 32'(ras_full), 32'd0);
        check("reset_underflow", 32'(ras_underflow), 32'd0);
        reset = 1'b0;

        // Free-running increment
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("incr_%0d", i), next_instruction, 32'(4 * i));
        end
        check("incr_empty", 32'(ras_empty), 32'd1);

        // Stall holds, jump overrides stall
        do_jump(32'h10, 1'b0);
        check("jump_0x10", next_instruction, 32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_%0d", i), next_instruction, 32'h10);
        end
        jump = 1'b1;
        jump_location = 32'h80;
        step();
        check("jump_over_stall", next_instruction, 32'h80);
        idle_inputs();

        // Call then return
        do_jump(32'h20, 1'b0);
        check("goto_0x20", next_instruction, 32'h20);
        do_jump(32'h100, 1'b1);
        check("call_pc", next_instruction, 32'h100);
        check("call_not_empty", 32'(ras_empty), 32'd0);
        step();
        check("after_call_1", next_instruction, 32'h104);
        step();
        check("after_call_2", next_instruction, 32'h108);
        ret = 1'b1;
        step();
        ret = 1'b0;
        check("ret_pc", next_instruction, 32'h24);
        check("ret_empty", 32'(ras_empty), 32'd1);

        // Overflow: five nested calls into a 4-deep stack
        do_jump(32'h0, 1'b0);
        check("goto_0x0", next_instruction, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            do_jump(32'(16 * i), 1'b1);
            check($sformatf("nest_call_%0d", i), next_instruction, 32'(16 * i));
            if (i == 3) check("full_after_3", 32'(ras_full), 32'd0);
            if (i == 4) check("full_after_4", 32'(ras_full), 32'd1);
        end
        check("full_after_5", 32'(ras_full), 32'd1);
        ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("nest_ret_%0d", i), next_instruction, 32'(32'h44 - 16 * i));
            if (i == 0) check("not_full_after_pop", 32'(ras_full), 32'd0);
        end
        check("nest_empty", 32'(ras_empty), 32'd1);
        check("no_underflow_yet", 32'(ras_underflow), 32'd0);
        step();
        check("underflow_pc", next_instruction, 32'h18);
        check("underflow_pulse", 32'(ras_underflow), 32'd1);
        ret = 1'b0;
        step();
        check("underflow_clear", 32'(ras_underflow), 32'd0);
        check("after_underflow_pc", next_instruction, 32'h1c);

        // ret beats a simultaneous jump+call
        do_jump(32'h4c, 1'b1);     // pushes 0x20
        do_jump(32'h200, 1'b1);    // pushes 0x50
        check("pre_same_cycle_pc", next_instruction, 32'h200);
        ret = 1'b1;
        jump = 1'b1;
        call = 1'b1;
        jump_location = 32'h300;
        step();
        idle_inputs();
        check("same_cycle_pc", next_instruction, 32'h50);
        check("same_cycle_not_empty", 32'(ras_empty), 32'd0);
        ret = 1'b1;
        step();
        ret = 1'b0;
        check("same_cycle_no_push", next_instruction, 32'h20);
        check("same_cycle_empty", 32'(ras_empty), 32'd1);

        // Address wraps modulo 2^32
        do_jump(32'hFFFF_FFFC, 1'b0);
        check("wrap_pre", next_instruction, 32'hFFFF_FFFC);
        step();
        check("wrap_post", next_instruction, 32'h0);

        // Asynchronous reset between edges
        do_jump(32'h1000, 1'b1);
        do_jump(32'h1234, 1'b1);
        check("pre_areset_pc", next_instruction, 32'h1234);
        check("pre_areset_full", 32'(ras_full), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("areset_pc", next_instruction, 32'h0);
        check("areset_empty", 32'(ras_empty), 32'd1);
        step();
        check("areset_hold", next_instruction, 32'h0);
        reset = 1'b0;
        step();
        check("post_reset_incr", next_instruction, 32'h4);
        ret = 1'b1;
        step();
        ret = 1'b0;
        check("post_reset_ret_pc", next_instruction, 32'h8);
        check("post_reset_underflow", 32'(ras_underflow), 32'd1);

        // Unaligned jump target
        do_jump(32'h202, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc", next_instruction, 32'h200);
        check("align_pulse", 32'(misaligned), 32'd1);
        step();
        check("align_pulse_clear", 32'(misaligned), 32'd0);
        check("align_next", next_instruction, 32'h204);
`else
        check("unaligned_pc", next_instruction, 32'h202);
        step();
        check("unaligned_next", next_instruction, 32'h206);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
